fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/rv_pkg.sv | 25 ++
 rtl/fetch_unit_pc_next_sel.sv | 30 +++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared fetch-stage constants, FSM state type and next-PC select encoding.
package rv_pkg;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  // Source chosen by the next-PC mux.
  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2,
    PC_RESET    = 2'd3
  } pc_sel_t;

  // Byte address to instruction-memory word index.
  function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
    return {2'b00, byte_addr[31:2]};
  endfunction

endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// Combinational next-PC mux: hold, +4, redirect, reset.
// A misaligned redirect target never reaches the PC; the mux holds instead
// and flags the target so the fetch FSM can record the fault.
module pc_next_sel
  import rv_pkg::*;
(
  input  pc_sel_t     sel,
  input  logic [31:0] pc,
  input  logic [31:0] reset_pc,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc_next,
  output logic        misaligned
);

  // Alignment check depends only on the target, so it never loops back through sel.
  assign misaligned = |redirect_target[1:0];

  // Select the next PC; +4 wraps modulo 2^32.
  always_comb begin
    pc_next = pc;
    case (sel)
      PC_HOLD:     pc_next = pc;
      PC_INC:      pc_next = pc + 32'd4;
      PC_REDIRECT: pc_next = misaligned ? pc : redirect_target;
      PC_RESET:    pc_next = reset_pc;
      default:     pc_next = pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Single-stage instruction fetch with stall, redirect, EBREAK halt and
// sticky misaligned-redirect fault.
//
// Handshake: decode asserts stall when it cannot accept; while stalled the
// fetched instruction (if_valid/if_instr/if_pc) and PC are held. A redirect
// wins over stall, kills the in-flight fetch (one bubble) and restarts at the
// target. Memory is read combinationally from imem_addr in the same cycle.
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter bit          HALT_ON_EBREAK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        halted,
  output logic        fault
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic         fault_q, fault_d;

  pc_sel_t      pc_sel;
  logic         target_misaligned;
  logic         is_ebreak;

  pc_next_sel u_pc_next_sel (
    .sel             (pc_sel),
    .pc              (pc_q),
    .reset_pc        (RESET_PC),
    .redirect_target (redirect_target),
    .pc_next         (pc_d),
    .misaligned      (target_misaligned)
  );

  assign is_ebreak = HALT_ON_EBREAK && (imem_rdata == EBREAK);

  // Next-state decode: reset, then redirect over stall, then normal fetch; HALT holds everything.
  always_comb begin
    pc_sel     = PC_HOLD;
    state_d    = state_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    fault_d    = fault_q;
    if (rst) begin
      pc_sel     = PC_RESET;
      state_d    = RUN;
      if_valid_d = 1'b0;
      if_instr_d = NOP;
      if_pc_d    = RESET_PC;
      fault_d    = 1'b0;
    end else if (state_q == RUN) begin
      if (redirect_valid) begin
        pc_sel     = PC_REDIRECT;
        if_valid_d = 1'b0;
        if (target_misaligned) begin
          fault_d = 1'b1;
          state_d = HALT;
        end
      end else if (!stall) begin
        if_valid_d = 1'b1;
        if_instr_d = imem_rdata;
        if_pc_d    = pc_q;
        if (is_ebreak) begin
          // Keep the PC parked on the EBREAK so imem_addr points at it while halted.
          state_d = HALT;
        end else begin
          pc_sel = PC_INC;
        end
      end
    end
  end

  // State registers; PC reset value arrives through the next-PC mux.
  always_ff @(posedge clk) begin
    pc_q <= pc_d;
    if (rst) begin
      state_q    <= RUN;
      if_valid_q <= 1'b0;
      if_instr_q <= NOP;
      if_pc_q    <= RESET_PC;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      fault_q    <= fault_d;
    end
  end

  assign imem_addr = word_index(pc_q);
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign halted    = (state_q == HALT);
  assign fault     = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written halt/fault/wrap
// sequences, then randomized traffic against a behavioural model.
module tb_fetch_unit;
  import rv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        halted;
  logic        fault;

  fetch_unit #(
    .RESET_PC       (32'h0000_0000),
    .HALT_ON_EBREAK (1'b1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .stall           (stall),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .halted          (halted),
    .fault           (fault)
  );

  // 256-word instruction memory, read combinationally.
  logic [31:0] mem [0:255];
  assign imem_rdata = mem[imem_addr[7:0]];

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_pc, m_instr, m_ifpc;
  logic        m_valid, m_halt, m_fault;

  // One clock of the fetch rules, using the word the model's PC addresses.
  task automatic model_step(input logic r, input logic rv, input logic [31:0] rt, input logic st);
    logic [31:0] word;
    word = mem[m_pc[9:2]];
    if (r) begin
      m_pc = 32'h0; m_valid = 1'b0; m_instr = NOP; m_ifpc = 32'h0;
      m_halt = 1'b0; m_fault = 1'b0;
    end else if (m_halt) begin
      // everything frozen until reset
    end else if (rv) begin
      m_valid = 1'b0;
      if ((rt % 4) != 0) begin
        m_fault = 1'b1;
        m_halt  = 1'b1;
      end else begin
        m_pc = rt;
      end
    end else if (!st) begin
      m_instr = word;
      m_ifpc  = m_pc;
      m_valid = 1'b1;
      if (word == EBREAK) m_halt = 1'b1;
      else                m_pc   = m_pc + 32'd4;
    end
  endtask

  // ---------------- driver ----------------
  // Drive inputs just after an edge, advance the model, wait for the next edge + 1.
  task automatic apply(input logic r, input logic rv, input logic [31:0] rt, input logic st);
    rst = r; redirect_valid = rv; redirect_target = rt; stall = st;
    model_step(r, rv, rt, st);
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".imem_addr"}, imem_addr, {2'b00, m_pc[31:2]});
    check({tag, ".if_valid"},  {31'b0, if_valid}, {31'b0, m_valid});
    check({tag, ".if_instr"},  if_instr, m_instr);
    check({tag, ".if_pc"},     if_pc, m_ifpc);
    check({tag, ".halted"},    {31'b0, halted}, {31'b0, m_halt});
    check({tag, ".fault"},     {31'b0, fault}, {31'b0, m_fault});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rt;
    logic        st;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_halt;
    logic        e_fault;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rt, input logic st,
                              input logic [31:0] ea, input logic ev, input logic [31:0] ei,
                              input logic [31:0] ep, input logic eh, input logic ef);
    vec_t v;
    v.rst = r; v.rv = rv; v.rt = rt; v.st = st;
    v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc = ep; v.e_halt = eh; v.e_fault = ef;
    return v;
  endfunction

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0; stall = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = i;
    m_pc = 32'h0; m_valid = 1'b0; m_instr = NOP; m_ifpc = 32'h0; m_halt = 1'b0; m_fault = 1'b0;

    //                rst rv  target        st  addr    v  instr         if_pc         h  f
    vecs[0]  = mk(1, 0, 32'h0,  0, 32'd0,  0, 32'h13, 32'h0,  0, 0); // reset
    vecs[1]  = mk(1, 0, 32'h0,  0, 32'd0,  0, 32'h13, 32'h0,  0, 0);
    vecs[2]  = mk(0, 0, 32'h0,  0, 32'd1,  1, 32'd0,  32'h0,  0, 0); // sequential fetch
    vecs[3]  = mk(0, 0, 32'h0,  0, 32'd2,  1, 32'd1,  32'h4,  0, 0);
    vecs[4]  = mk(0, 0, 32'h0,  0, 32'd3,  1, 32'd2,  32'h8,  0, 0);
    vecs[5]  = mk(0, 0, 32'h0,  0, 32'd4,  1, 32'd3,  32'hC,  0, 0);
    vecs[6]  = mk(0, 0, 32'h0,  1, 32'd4,  1, 32'd3,  32'hC,  0, 0); // stall x3 at addr 4
    vecs[7]  = mk(0, 0, 32'h0,  1, 32'd4,  1, 32'd3,  32'hC,  0, 0);
    vecs[8]  = mk(0, 0, 32'h0,  1, 32'd4,  1, 32'd3,  32'hC,  0, 0);
    vecs[9]  = mk(0, 0, 32'h0,  0, 32'd5,  1, 32'd4,  32'h10, 0, 0); // resume
    vecs[10] = mk(1, 0, 32'h0,  0, 32'd0,  0, 32'h13, 32'h0,  0, 0);
    vecs[11] = mk(0, 0, 32'h0,  0, 32'd1,  1, 32'd0,  32'h0,  0, 0);
    vecs[12] = mk(0, 0, 32'h0,  0, 32'd2,  1, 32'd1,  32'h4,  0, 0); // pc = 8
    vecs[13] = mk(0, 1, 32'h64, 0, 32'd25, 0, 32'd1,  32'h4,  0, 0); // redirect -> bubble
    vecs[14] = mk(0, 0, 32'h0,  0, 32'd26, 1, 32'd25, 32'h64, 0, 0);
    vecs[15] = mk(0, 1, 32'h20, 1, 32'd8,  0, 32'd25, 32'h64, 0, 0); // redirect beats stall
    vecs[16] = mk(0, 0, 32'h0,  0, 32'd9,  1, 32'd8,  32'h20, 0, 0);

    for (int i = 0; i < 17; i++) begin
      apply(vecs[i].rst, vecs[i].rv, vecs[i].rt, vecs[i].st);
      check($sformatf("vec%0d.imem_addr", i), imem_addr, vecs[i].e_addr);
      check($sformatf("vec%0d.if_valid", i),  {31'b0, if_valid}, {31'b0, vecs[i].e_valid});
      check($sformatf("vec%0d.if_instr", i),  if_instr, vecs[i].e_instr);
      check($sformatf("vec%0d.if_pc", i),     if_pc, vecs[i].e_pc);
      check($sformatf("vec%0d.halted", i),    {31'b0, halted}, {31'b0, vecs[i].e_halt});
      check($sformatf("vec%0d.fault", i),     {31'b0, fault}, {31'b0, vecs[i].e_fault});
    end

    // ---- EBREAK at word 25 halts; redirects and stalls ignored; reset recovers ----
    mem[25] = EBREAK;
    apply(1, 0, 32'h0, 0);
    apply(0, 1, 32'h64, 0);
    check("ebk.redirect_addr", imem_addr, 32'd25);
    apply(0, 0, 32'h0, 0);
    check("ebk.halted",   {31'b0, halted}, 32'd1);
    check("ebk.if_valid", {31'b0, if_valid}, 32'd1);
    check("ebk.if_instr", if_instr, EBREAK);
    check("ebk.if_pc",    if_pc, 32'h64);
    check("ebk.addr",     imem_addr, 32'd25);
    for (int i = 0; i < 22; i++) begin
      apply(0, (i % 2 == 0), 32'h100, $urandom_range(0, 1) == 1);
      check("ebk.hold_addr",   imem_addr, 32'd25);
      check("ebk.hold_halted", {31'b0, halted}, 32'd1);
      check("ebk.hold_if_pc",  if_pc, 32'h64);
      check("ebk.hold_instr",  if_instr, EBREAK);
    end
    apply(1, 1, 32'h100, 1);
    check("ebk.rst_addr",   imem_addr, 32'd0);
    check("ebk.rst_halted", {31'b0, halted}, 32'd0);
    check("ebk.rst_valid",  {31'b0, if_valid}, 32'd0);
    mem[25] = 32'd25;

    // ---- misaligned redirect faults and halts without moving the PC ----
    apply(0, 0, 32'h0, 0);
    apply(0, 0, 32'h0, 0);
    apply(0, 1, 32'h66, 0);
    check("flt.addr",     imem_addr, 32'd2);
    check("flt.fault",    {31'b0, fault}, 32'd1);
    check("flt.halted",   {31'b0, halted}, 32'd1);
    check("flt.if_valid", {31'b0, if_valid}, 32'd0);
    apply(0, 1, 32'h40, 0);
    check("flt.sticky",   {31'b0, fault}, 32'd1);
    check("flt.addr2",    imem_addr, 32'd2);
    apply(1, 1, 32'h66, 1);
    check("flt.rst_fault", {31'b0, fault}, 32'd0);
    check("flt.rst_addr",  imem_addr, 32'd0);

    // ---- PC wraps modulo 2^32 ----
    apply(0, 1, 32'hFFFF_FFFC, 0);
    check("wrap.addr_top", imem_addr, 32'h3FFF_FFFF);
    apply(0, 0, 32'h0, 0);
    check("wrap.addr",  imem_addr, 32'd0);
    check("wrap.if_pc", if_pc, 32'hFFFF_FFFC);
    check("wrap.instr", if_instr, 32'd255);
    check("wrap.fault", {31'b0, fault}, 32'd0);

    // ---- reset asserted mid-stall ----
    apply(0, 0, 32'h0, 0);
    apply(0, 0, 32'h0, 1);
    apply(1, 0, 32'h0, 1);
    check("rststall.addr",  imem_addr, 32'd0);
    check("rststall.valid", {31'b0, if_valid}, 32'd0);
    check("rststall.instr", if_instr, NOP);

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 23) == 0) ? EBREAK : $urandom;
    apply(1, 0, 32'h0, 0);
    check_model("rnd_reset");
    for (int i = 0; i < 3000; i++) begin
      logic        r, rv, st;
      logic [31:0] rt;
      r  = ($urandom_range(0, 39) == 0);
      rv = ($urandom_range(0, 6) == 0);
      st = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0:       rt = {$urandom, 2'b00} | 32'($urandom_range(1, 3));
        1:       rt = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
        default: rt = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      endcase
      apply(r, rv, rt, st);
      check_model("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
